dhms_countdown: RTL and testbench
=================================

Name: dhms_countdown

Overview:
- Day/hour/minute/second countdown timer; the down-counting counterpart of the free-running day-hour-minute-second clock.
- Software or a controller loads a duration, starts it, can pause it, and receives an expiry pulse when the count reaches zero.
- An internal prescaler divides the input clock to a 1 s decrement tick, so the block runs from the same fast clock as the up-counting clock.

Parameters:
- TICKS_PER_SEC, 5, input clock cycles per decrement; must be >= 1. With 1, a decrement occurs every enabled cycle.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- load  input  1  capture ld_* into the count registers
- ld_day  input  5  load value, days (0..30)
- ld_hr  input  5  load value, hours (0..23)
- ld_min  input  6  load value, minutes (0..59)
- ld_sec  input  6  load value, seconds (0..59)
- start  input  1  begin or resume counting
- stop  input  1  pause counting
- day  output  5  remaining days
- hr  output  5  remaining hours
- min  output  6  remaining minutes
- sec  output  6  remaining seconds
- running  output  1  high in RUN
- expired  output  1  high in DONE
- done  output  1  one-cycle pulse on expiry

Behaviour:
- Reset (rst=0, asynchronous; also mid-run):
  - day/hr/min/sec = 0, prescaler = 0, state = IDLE.
  - running = 0, expired = 0, done = 0.
- States:
  - IDLE: loaded value present, not counting.
  - RUN: counting down.
  - PAUSE: counting suspended.
  - DONE: count reached zero.
- Input priority per cycle: load > stop > start.
- load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Captures clamped values: sec and min >59 become 59, hr >23 becomes 23, day >30 becomes 30.
  - Clears the prescaler, clears expired, and sets state to IDLE.
- start:
  - From IDLE or PAUSE: if the count is non-zero, go to RUN.
  - If the count is zero: go to DONE, with done=1 for that one cycle and expired=1.
  - Ignored in RUN and DONE.
- stop:
  - RUN goes to PAUSE. The prescaler value is held, not cleared.
  - Ignored in all other states.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1, incrementing only in RUN.
  - A tick occurs on the edge where the prescaler equals TICKS_PER_SEC-1; the prescaler then wraps to 0.
  - The first decrement lands on the TICKS_PER_SEC-th RUN edge after the edge that registered start.
- Decrement on tick (borrow chain):
  - sec: if sec>0, sec-1. Otherwise sec=59 and borrow from min.
  - min: on borrow, if min>0, min-1. Otherwise min=59 and borrow from hr.
  - hr: on borrow, if hr>0, hr-1. Otherwise hr=23 and borrow from day.
  - day: on borrow, day-1. Day never underflows, because a zero count is never in RUN.
- Expiry:
  - On the tick edge where the count goes from 0:00:00:01 to all-zero, the registers become zero and the state becomes DONE.
  - On that same edge, done=1 for exactly one cycle, expired=1 and running=0.
- DONE:
  - Count holds at zero and expired stays high.
  - Only load or reset leaves DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: TICKS_PER_SEC=5; assert rst=0 mid-count with 0d 2h 3m 4s running -> all outputs 0 immediately (asynchronous), state IDLE; after release, no decrement occurs without start.
- Minute countdown: load 0d 0h 1m 0s, start -> 5th edge after start gives min=0 sec=59; 300th edge gives all zero, done=1 for one cycle, expired=1, running=0; count stays at zero afterwards.
- Full borrow: load 1d 0h 0m 0s, start -> first tick gives day=0 hr=23 min=59 sec=59; running stays 1.
- Pause/resume: load 0d 0h 0m 3s, start; assert stop on the 3rd RUN edge -> sec stays 3 while stopped (any length); start -> sec=2 after 2 more RUN edges (prescaler held, not cleared); stop and start together in RUN -> goes to PAUSE.
- Clamp and load rules:
  - Load ld_day=31 ld_hr=31 ld_min=60 ld_sec=63 -> 30d 23h 59m 59s.
  - load asserted in RUN -> ignored, count continues.
  - load in DONE -> expired=0, state IDLE with the new value.
- Zero start: load all zeros, start -> next edge done=1 (one cycle) and expired=1; no decrement attempted.

Source files
------------

// File: rtl/dhms_countdown.sv
// Day/hour/minute/second countdown timer with built-in 1 s prescaler.
// Loads a clamped duration, counts down in RUN, and pulses done on reaching zero.
module dhms_countdown #(
    parameter int TICKS_PER_SEC = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] ld_day,
    input  logic [4:0] ld_hr,
    input  logic [5:0] ld_min,
    input  logic [5:0] ld_sec,
    input  logic       start,
    input  logic       stop,
    output logic [4:0] day,
    output logic [4:0] hr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [4:0]    day_n, hr_n;
    logic [5:0]    min_n, sec_n;
    logic          done_n;
    logic          is_zero, last_sec, tick;

    assign is_zero  = (day == 5'd0) && (hr == 5'd0) && (min == 6'd0) && (sec == 6'd0);
    assign last_sec = (day == 5'd0) && (hr == 5'd0) && (min == 6'd0) && (sec == 6'd1);
    assign tick     = (presc == PRE_LAST);

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
        state_n = state;
        presc_n = presc;
        day_n   = day;
        hr_n    = hr;
        min_n   = min;
        sec_n   = sec;
        done_n  = 1'b0;

        if (load && (state != S_RUN)) begin
            day_n   = (ld_day > 5'd30) ? 5'd30 : ld_day;
            hr_n    = (ld_hr  > 5'd23) ? 5'd23 : ld_hr;
            min_n   = (ld_min > 6'd59) ? 6'd59 : ld_min;
            sec_n   = (ld_sec > 6'd59) ? 6'd59 : ld_sec;
            presc_n = '0;
            state_n = S_IDLE;
        end else if (stop && (state == S_RUN)) begin
            // Prescaler is held so a resume finishes the interrupted second.
            state_n = S_PAUSE;
        end else if (start && ((state == S_IDLE) || (state == S_PAUSE))) begin
            if (is_zero) begin
                state_n = S_DONE;
                done_n  = 1'b1;
            end else begin
                state_n = S_RUN;
            end
        end else if (state == S_RUN) begin
            if (tick) begin
                presc_n = '0;
                if (sec != 6'd0) begin
                    sec_n = sec - 6'd1;
                end else begin
                    sec_n = 6'd59;
                    if (min != 6'd0) begin
                        min_n = min - 6'd1;
                    end else begin
                        min_n = 6'd59;
                        if (hr != 5'd0) begin
                            hr_n = hr - 5'd1;
                        end else begin
                            // A zero count never reaches RUN, so day is non-zero here.
                            hr_n  = 5'd23;
                            day_n = day - 5'd1;
                        end
                    end
                end
                if (last_sec) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end
            end else begin
                presc_n = presc + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            presc   <= '0;
            day     <= '0;
            hr      <= '0;
            min     <= '0;
            sec     <= '0;
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            day     <= day_n;
            hr      <= hr_n;
            min     <= min_n;
            sec     <= sec_n;
            running <= (state_n == S_RUN);
            expired <= (state_n == S_DONE);
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_dhms_countdown.sv
// Directed testbench for dhms_countdown with TICKS_PER_SEC = 5.
// Each task drives one scenario and checks hand-computed expectations inline.
module tb_dhms_countdown;

    logic       clk;
    logic       rst;
    logic       load;
    logic [4:0] ld_day;
    logic [4:0] ld_hr;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;
    logic       start;
    logic       stop;
    logic [4:0] day;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic       running;
    logic       expired;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    dhms_countdown #(.TICKS_PER_SEC(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .ld_day  (ld_day),
        .ld_hr   (ld_hr),
        .ld_min  (ld_min),
        .ld_sec  (ld_sec),
        .start   (start),
        .stop    (stop),
        .day     (day),
        .hr      (hr),
        .min     (min),
        .sec     (sec),
        .running (running),
        .expired (expired),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] dhms(input int d, input int h, input int m, input int s);
        return {d[4:0], h[4:0], m[5:0], s[5:0]};
    endfunction

    function automatic string fmt(input logic [21:0] v);
        return $sformatf("%0d:%0d:%0d:%0d", v[21:17], v[16:12], v[11:6], v[5:0]);
    endfunction

    // Advance n rising edges; inputs change and outputs are sampled 1 ns after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        ld_day = '0; ld_hr = '0; ld_min = '0; ld_sec = '0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic do_load(input int d, input int h, input int m, input int s);
        ld_day = d[4:0]; ld_hr = h[4:0]; ld_min = m[5:0]; ld_sec = s[5:0];
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic chk_cnt(input string name, input logic [21:0] exp);
        n_checks++;
        if ({day, hr, min, sec} !== exp) begin
            n_fail++;
            $display("FAIL %s: count=%s expected %s", name, fmt({day, hr, min, sec}), fmt(exp));
        end
    endtask

    task automatic chk_flags(input string name, input logic [2:0] exp);
        n_checks++;
        if ({running, expired, done} !== exp) begin
            n_fail++;
            $display("FAIL %s: {running,expired,done}=%b expected %b", name, {running, expired, done}, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        ld_day = '0; ld_hr = '0; ld_min = '0; ld_sec = '0;
        #3;
        chk_cnt("reset_initial_count", dhms(0, 0, 0, 0));
        chk_flags("reset_initial_flags", 3'b000);
        step(1);
        rst = 1'b1;
        step(1);
        do_load(0, 2, 3, 4);
        do_start();
        step(7);
        chk_cnt("reset_prerun_count", dhms(0, 2, 3, 3));
        chk_flags("reset_prerun_flags", 3'b100);
        #2;
        rst = 1'b0;
        #1;
        chk_cnt("reset_async_count", dhms(0, 0, 0, 0));
        chk_flags("reset_async_flags", 3'b000);
        step(2);
        rst = 1'b1;
        step(10);
        chk_cnt("reset_release_count", dhms(0, 0, 0, 0));
        chk_flags("reset_release_flags", 3'b000);
        do_load(0, 0, 0, 9);
        step(10);
        chk_cnt("reset_no_start_hold", dhms(0, 0, 0, 9));
        chk_flags("reset_no_start_flags", 3'b000);
    endtask

    task automatic test_minute_countdown();
        do_reset();
        do_load(0, 0, 1, 0);
        do_start();
        step(4);
        chk_cnt("minute_before_tick", dhms(0, 0, 1, 0));
        step(1);
        chk_cnt("minute_first_tick", dhms(0, 0, 0, 59));
        chk_flags("minute_running", 3'b100);
        step(294);
        chk_cnt("minute_edge_299", dhms(0, 0, 0, 1));
        chk_flags("minute_edge_299_flags", 3'b100);
        step(1);
        chk_cnt("minute_expiry_count", dhms(0, 0, 0, 0));
        chk_flags("minute_expiry_flags", 3'b011);
        step(1);
        chk_flags("minute_done_one_cycle", 3'b010);
        step(10);
        chk_cnt("minute_hold_zero", dhms(0, 0, 0, 0));
        chk_flags("minute_hold_flags", 3'b010);
    endtask

    task automatic test_full_borrow();
        do_reset();
        do_load(1, 0, 0, 0);
        do_start();
        step(4);
        chk_cnt("borrow_before_tick", dhms(1, 0, 0, 0));
        step(1);
        chk_cnt("borrow_first_tick", dhms(0, 23, 59, 59));
        chk_flags("borrow_running", 3'b100);
    endtask

    task automatic test_pause_resume();
        do_reset();
        do_load(0, 0, 0, 3);
        do_start();
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk_cnt("pause_count", dhms(0, 0, 0, 3));
        chk_flags("pause_flags", 3'b000);
        step(20);
        chk_cnt("pause_hold", dhms(0, 0, 0, 3));
        do_start();
        chk_flags("resume_flags", 3'b100);
        step(1);
        chk_cnt("resume_edge1", dhms(0, 0, 0, 3));
        step(1);
        chk_cnt("resume_edge2_tick", dhms(0, 0, 0, 2));
        stop = 1'b1; start = 1'b1;
        step(1);
        stop = 1'b0; start = 1'b0;
        chk_flags("stop_beats_start", 3'b000);
        step(10);
        chk_cnt("stop_start_hold", dhms(0, 0, 0, 2));
    endtask

    task automatic test_load_rules();
        do_reset();
        do_load(31, 31, 60, 63);
        chk_cnt("clamp_load", dhms(30, 23, 59, 59));
        chk_flags("clamp_idle_flags", 3'b000);
        do_start();
        step(2);
        ld_day = 5'd0; ld_hr = 5'd0; ld_min = 6'd0; ld_sec = 6'd5;
        load = 1'b1;
        step(1);
        load = 1'b0;
        chk_cnt("load_in_run_ignored", dhms(30, 23, 59, 59));
        chk_flags("load_in_run_flags", 3'b100);
        step(2);
        chk_cnt("load_in_run_continues", dhms(30, 23, 59, 58));
    endtask

    task automatic test_zero_start();
        do_reset();
        do_load(0, 0, 0, 0);
        do_start();
        chk_cnt("zero_start_count", dhms(0, 0, 0, 0));
        chk_flags("zero_start_flags", 3'b011);
        step(1);
        chk_flags("zero_start_done_cleared", 3'b010);
        do_start();
        step(10);
        chk_cnt("done_hold_count", dhms(0, 0, 0, 0));
        chk_flags("done_start_ignored", 3'b010);
        do_load(0, 0, 2, 7);
        chk_cnt("load_in_done_count", dhms(0, 0, 2, 7));
        chk_flags("load_in_done_flags", 3'b000);
        step(5);
        chk_cnt("load_in_done_idle_hold", dhms(0, 0, 2, 7));
    endtask

    initial begin
        test_reset();
        test_minute_countdown();
        test_full_borrow();
        test_pause_resume();
        test_load_rules();
        test_zero_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
